// File: rtl/bus_initiator.sv
// bus_initiator: turns one accepted command into a single request on a simple
// req/ack bus, then returns a one-cycle completion strobe.
// A write completes when the responder acks it. A read is acked first and
// completes later, when the responder strobes bus_resp_i.
// Optional build macro BUS_INITIATOR_TIMEOUT_EN adds a watchdog. It aborts a
// transaction that has spent BUS_TIMEOUT cycles in REQ+WAIT and reports it with
// rsp_err_o=1 and all-ones data. Without the macro, rsp_err_o is tied to 0.
module bus_initiator #(
  parameter int unsigned BUS_TIMEOUT = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_req_i,
  output logic        cmd_ack_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_bi,
  input  logic [3:0]  cmd_be_bi,
  input  logic [31:0] cmd_wdata_bi,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi,
  output logic        rsp_req_o,
  output logic [31:0] rsp_rdata_bo,
  output logic        rsp_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;

  assign cmd_ack_o = (state == IDLE);
  assign busy_o    = (state != IDLE);

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BUS_TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             rsp_err_q;

  assign tmo_hit   = (state != IDLE) && (tmo_cnt == TERM);
  assign rsp_err_o = rsp_err_q;

  // Watchdog: zero while idle, so it starts at 0 in the first REQ cycle.
  // It cannot wrap, because reaching TERM forces the FSM back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign rsp_err_o = 1'b0;
`endif

  // Transaction FSM with registered bus request and completion outputs.
  // A completion seen at the terminal count takes priority over the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_bo  <= '0;
      bus_be_bo    <= '0;
      bus_wdata_bo <= '0;
      rsp_req_o    <= 1'b0;
      rsp_rdata_bo <= '0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      rsp_req_o <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_req_i) begin
            bus_we_o     <= cmd_we_i;
            bus_addr_bo  <= cmd_addr_bi;
            bus_be_bo    <= cmd_be_bi;
            bus_wdata_bo <= cmd_wdata_bi;
            bus_req_o    <= 1'b1;
            state        <= REQ;
          end
        end

        REQ: begin
          if (bus_ack_i && bus_we_o) begin
            bus_req_o    <= 1'b0;
            rsp_req_o    <= 1'b1;
            rsp_rdata_bo <= '0;
            state        <= IDLE;
          end
`ifdef BUS_INITIATOR_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_req_o    <= 1'b0;
            rsp_req_o    <= 1'b1;
            rsp_rdata_bo <= 32'hFFFF_FFFF;
            rsp_err_q    <= 1'b1;
            state        <= IDLE;
          end
`endif
          else if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (bus_resp_i) begin
            rsp_req_o    <= 1'b1;
            rsp_rdata_bo <= bus_rdata_bi;
            state        <= IDLE;
          end
`ifdef BUS_INITIATOR_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_req_o    <= 1'b1;
            rsp_rdata_bo <= 32'hFFFF_FFFF;
            rsp_err_q    <= 1'b1;
            state        <= IDLE;
          end
`endif
        end

        default: begin
          bus_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed vectors with hand-computed expectations.
// Inputs change 1ns after a rising edge, and outputs are sampled at that same point.
// The timeout scenarios run only when BUS_INITIATOR_TIMEOUT_EN is defined.
// Otherwise the bench checks that an unanswered read simply keeps waiting.
module tb_bus_initiator;

  logic        clk_gen;
  logic        rst_n;
  logic        cmd_req;
  logic        cmd_ack;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_resp;
  logic [31:0] bus_rdata;
  logic        rsp_req;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  bus_initiator #(.BUS_TIMEOUT(8)) dut (
    .clk_i        (clk_gen),
    .rst_ni       (rst_n),
    .cmd_req_i    (cmd_req),
    .cmd_ack_o    (cmd_ack),
    .cmd_we_i     (cmd_we),
    .cmd_addr_bi  (cmd_addr),
    .cmd_be_bi    (cmd_be),
    .cmd_wdata_bi (cmd_wdata),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_bo  (bus_addr),
    .bus_be_bo    (bus_be),
    .bus_wdata_bo (bus_wdata),
    .bus_ack_i    (bus_ack),
    .bus_resp_i   (bus_resp),
    .bus_rdata_bi (bus_rdata),
    .rsp_req_o    (rsp_req),
    .rsp_rdata_bo (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy)
  );

  // Free-running 10ns clock.
  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
    cmd_req   = req;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_be    = be;
    cmd_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk_gen);
    #1;
  endtask

  // Directed scenario sequence.
  initial begin
    rst_n     = 1'b0;
    bus_ack   = 1'b0;
    bus_resp  = 1'b0;
    bus_rdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset values while reset is held.
    #3;
    checkOutput("rst_bus_req",   32'(bus_req),   32'h0);
    checkOutput("rst_busy",      32'(busy),      32'h0);
    checkOutput("rst_rsp_req",   32'(rsp_req),   32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
    checkOutput("rst_bus_addr",  bus_addr,       32'h0);
    checkOutput("rst_bus_wdata", bus_wdata,      32'h0);
    checkOutput("rst_cmd_ack",   32'(cmd_ack),   32'h1);
    tick();
    tick();
    rst_n = 1'b1;

    // Write with ack in the first REQ cycle.
    applyStimulus(1'b1, 1'b1, 32'h1000_0004, 4'hF, 32'h0000_0001);
    checkOutput("wr_idle_ack", 32'(cmd_ack), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("wr_bus_req",   32'(bus_req),   32'h1);
    checkOutput("wr_bus_we",    32'(bus_we),    32'h1);
    checkOutput("wr_bus_addr",  bus_addr,       32'h1000_0004);
    checkOutput("wr_bus_be",    32'(bus_be),    32'hF);
    checkOutput("wr_bus_wdata", bus_wdata,      32'h0000_0001);
    checkOutput("wr_cmd_ack",   32'(cmd_ack),   32'h0);
    checkOutput("wr_busy",      32'(busy),      32'h1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("wr_req_drop",   32'(bus_req),  32'h0);
    checkOutput("wr_rsp_req",    32'(rsp_req),  32'h1);
    checkOutput("wr_rsp_rdata",  rsp_rdata,     32'h0);
    checkOutput("wr_rsp_err",    32'(rsp_err),  32'h0);
    checkOutput("wr_ack_n2",     32'(cmd_ack),  32'h1);
    checkOutput("wr_addr_hold",  bus_addr,      32'h1000_0004);

    // A second write presented while rsp_req is high is accepted.
    applyStimulus(1'b1, 1'b1, 32'h2000_0008, 4'h3, 32'hDEAD_BEEF);
    bus_ack = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("b2b_bus_req",  32'(bus_req), 32'h1);
    checkOutput("b2b_bus_addr", bus_addr,     32'h2000_0008);
    checkOutput("b2b_bus_be",   32'(bus_be),  32'h3);
    checkOutput("b2b_rsp_low",  32'(rsp_req), 32'h0);
    tick();
    bus_ack = 1'b0;
    checkOutput("b2b_rsp_req",  32'(rsp_req), 32'h1);
    tick();
    checkOutput("b2b_rsp_fall", 32'(rsp_req), 32'h0);

    // A response strobe while idle is ignored.
    bus_resp  = 1'b1;
    bus_rdata = 32'h0000_1234;
    tick();
    checkOutput("idle_resp_rsp",   32'(rsp_req), 32'h0);
    checkOutput("idle_resp_busy",  32'(busy),    32'h0);
    checkOutput("idle_resp_rdata", rsp_rdata,    32'h0);

    // Read with a spurious response in the ack cycle.
    // The real response arrives one cycle after the ack.
    applyStimulus(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("rd_bus_req", 32'(bus_req), 32'h1);
    checkOutput("rd_bus_we",  32'(bus_we),  32'h0);
    bus_ack   = 1'b1;
    bus_resp  = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_ack   = 1'b0;
    checkOutput("rd_ackcyc_rsp", 32'(rsp_req), 32'h0);
    checkOutput("rd_req_drop",   32'(bus_req), 32'h0);
    checkOutput("rd_wait_busy",  32'(busy),    32'h1);
    bus_resp  = 1'b1;
    bus_rdata = 32'h0000_A5A5;
    tick();
    bus_resp  = 1'b0;
    bus_rdata = 32'h0;
    checkOutput("rd_rsp_req",   32'(rsp_req), 32'h1);
    checkOutput("rd_rsp_rdata", rsp_rdata,    32'h0000_A5A5);
    checkOutput("rd_rsp_err",   32'(rsp_err), 32'h0);
    checkOutput("rd_idle",      32'(busy),    32'h0);
    tick();
    checkOutput("rd_rsp_fall",  32'(rsp_req), 32'h0);
    checkOutput("rd_rdata_hold", rsp_rdata,   32'h0000_A5A5);

    // Write stalled by five cycles without ack.
    applyStimulus(1'b1, 1'b1, 32'h3000_0010, 4'h5, 32'hCAFE_F00D);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_bus_req",   32'(bus_req), 32'h1);
      checkOutput("stall_bus_addr",  bus_addr,     32'h3000_0010);
      checkOutput("stall_bus_wdata", bus_wdata,    32'hCAFE_F00D);
      checkOutput("stall_rsp_low",   32'(rsp_req), 32'h0);
      tick();
    end
    checkOutput("stall6_bus_req", 32'(bus_req), 32'h1);
    checkOutput("stall6_bus_be",  32'(bus_be),  32'h5);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("stall_rsp_req", 32'(rsp_req), 32'h1);
    checkOutput("stall_req_off", 32'(bus_req), 32'h0);
    tick();

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // Read acked but never answered: the timeout fires after 8 cycles in REQ+WAIT.
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("tmo_wait_rsp",  32'(rsp_req), 32'h0);
      checkOutput("tmo_wait_busy", 32'(busy),    32'h1);
      tick();
    end
    checkOutput("tmo_rsp_req",   32'(rsp_req), 32'h1);
    checkOutput("tmo_rsp_err",   32'(rsp_err), 32'h1);
    checkOutput("tmo_rsp_rdata", rsp_rdata,    32'hFFFF_FFFF);
    checkOutput("tmo_cmd_ack",   32'(cmd_ack), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h5000_0000, 4'hF, 32'h0000_0077);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("tmo_next_req",  32'(bus_req), 32'h1);
    checkOutput("tmo_next_addr", bus_addr,     32'h5000_0000);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("tmo_next_rsp", 32'(rsp_req), 32'h1);
    checkOutput("tmo_next_err", 32'(rsp_err), 32'h0);
    tick();

    // A response in the terminal-count cycle completes normally.
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("term_pre_rsp", 32'(rsp_req), 32'h0);
    bus_resp  = 1'b1;
    bus_rdata = 32'h0000_5A5A;
    tick();
    bus_resp  = 1'b0;
    bus_rdata = 32'h0;
    checkOutput("term_rsp_req",   32'(rsp_req), 32'h1);
    checkOutput("term_rsp_err",   32'(rsp_err), 32'h0);
    checkOutput("term_rsp_rdata", rsp_rdata,    32'h0000_5A5A);
    tick();
`endif

    // Reset asserted mid-WAIT aborts the read without a completion pulse.
    applyStimulus(1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
`ifndef BUS_INITIATOR_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      checkOutput("hang_rsp_req", 32'(rsp_req), 32'h0);
      checkOutput("hang_rsp_err", 32'(rsp_err), 32'h0);
      checkOutput("hang_busy",    32'(busy),    32'h1);
      tick();
    end
`else
    tick();
`endif
    checkOutput("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_bus_req",   32'(bus_req), 32'h0);
    checkOutput("mid_rst_busy",      32'(busy),    32'h0);
    checkOutput("mid_rst_bus_addr",  bus_addr,     32'h0);
    checkOutput("mid_rst_rsp_rdata", rsp_rdata,    32'h0);
    tick();
    checkOutput("mid_rst_rsp_req", 32'(rsp_req), 32'h0);
    rst_n = 1'b1;
    checkOutput("post_rst_cmd_ack", 32'(cmd_ack), 32'h1);
    checkOutput("post_rst_busy",    32'(busy),    32'h0);
    tick();
    checkOutput("post_rst_rsp_req", 32'(rsp_req), 32'h0);
    checkOutput("post_rst_ack2",    32'(cmd_ack), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
